// File: rtl/regfile_pkg.sv
// Shared register-file geometry and write-port arbitration types.
// Used by the write arbiter and by the register file itself.
package regfile_pkg;

  localparam int REG_AW         = 5;
  localparam int REG_DW         = 32;
  localparam int STARVE_LIM_DEF = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  // Register 0 is hardwired; writes to it are accepted but never enabled.
  function automatic logic wr_enabled(input logic [REG_AW-1:0] addr);
    return (addr != {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Two-requester register-file write-port arbiter. A (ALU) has priority.
// B (load/mul) is forced through after STARVE_LIM consecutive lost cycles.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
)
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_DW-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [REG_DW-1:0] b_data,
  output logic              b_ready,
  output logic              ew,
  output logic [REG_AW-1:0] rw,
  output logic [REG_DW-1:0] busW,
  output logic              starved
);

  localparam int            CW  = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0]     r_cnt;
  logic              r_ew;
  logic [REG_AW-1:0] r_rw;
  logic [REG_DW-1:0] r_busW;

  grant_e            w_grant;
  logic              w_lim;
  logic [REG_AW-1:0] w_addr;
  logic [REG_DW-1:0] w_data;

  assign w_lim   = (r_cnt == LIM);
  assign starved = w_lim;
  assign a_ready = (w_grant == GNT_A);
  assign b_ready = (w_grant == GNT_B);
  assign ew      = r_ew;
  assign rw      = r_rw;
  assign busW    = r_busW;

  // Grant selection: A wins contention until B has lost STARVE_LIM cycles in a row.
  always_comb begin
    w_grant = GNT_NONE;
    if (RST) begin
      w_grant = GNT_NONE;
    end else if (a_valid && b_valid) begin
      w_grant = w_lim ? GNT_B : GNT_A;
    end else if (a_valid) begin
      w_grant = GNT_A;
    end else if (b_valid) begin
      w_grant = GNT_B;
    end else begin
      w_grant = GNT_NONE;
    end
  end

  // Write-port mux; with no grant the A side is selected but never loaded.
  always_comb begin
    w_addr = a_addr;
    w_data = a_data;
    case (w_grant)
      GNT_A: begin
        w_addr = a_addr;
        w_data = a_data;
      end
      GNT_B: begin
        w_addr = b_addr;
        w_data = b_data;
      end
      default: begin
        w_addr = a_addr;
        w_data = a_data;
      end
    endcase
  end

  // Starvation counter: counts B's consecutive lost cycles, saturating at the limit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= {CW{1'b0}};
    end else if (b_valid && !b_ready) begin
      r_cnt <= w_lim ? r_cnt : (r_cnt + CW'(1));
    end else begin
      r_cnt <= {CW{1'b0}};
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ew   <= 1'b0;
      r_rw   <= {REG_AW{1'b0}};
      r_busW <= {REG_DW{1'b0}};
    end else if (w_grant != GNT_NONE) begin
      r_ew   <= wr_enabled(w_addr);
      r_rw   <= w_addr;
      r_busW <= w_data;
    end else begin
      r_ew   <= 1'b0;
      r_rw   <= r_rw;
      r_busW <= r_busW;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: directed vector table, then randomized
// handshake traffic compared against a behavioural arbitration model.
module tb_regfile_wr_arb;

  localparam int LIM = 3;

  logic        CLK, RST;
  logic        a_valid, b_valid, a_ready, b_ready, ew, starved;
  logic [4:0]  a_addr, b_addr, rw;
  logic [31:0] a_data, b_data, busW;

  int total = 0;
  int bad   = 0;

  // model state: B's consecutive losses and the last registered write
  int          m_lost;
  bit          m_ew;
  logic [4:0]  m_rw;
  logic [31:0] m_bus;

  typedef struct {
    bit rst; bit av; logic [4:0] aa; logic [31:0] ad;
    bit bv; logic [4:0] ba; logic [31:0] bd;
    bit ar; bit br; bit st; bit ew; logic [4:0] rw; logic [31:0] bus;
  } vec_t;

  vec_t tbl[$];

  regfile_wr_arb #(.STARVE_LIM(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .ew(ew), .rw(rw), .busW(busW), .starved(starved)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(bit rst, bit av, logic [4:0] aa, logic [31:0] ad,
                              bit bv, logic [4:0] ba, logic [31:0] bd,
                              bit ar, bit br, bit st, bit e, logic [4:0] r, logic [31:0] bus);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ar = ar; v.br = br; v.st = st; v.ew = e; v.rw = r; v.bus = bus;
    return v;
  endfunction

  // 0 = none, 1 = A, 2 = B, from the arbitration rules and current loss count
  function automatic int predict(bit rst, bit av, bit bv);
    if (rst) return 0;
    if (av && bv) return (m_lost >= LIM) ? 2 : 1;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    int g;
    bit e_ar, e_br, e_st;
    RST = v.rst; a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    #1;
    g = predict(v.rst, v.av, v.bv);
    if (use_tbl) begin
      e_ar = v.ar; e_br = v.br; e_st = v.st;
    end else begin
      e_ar = (g == 1); e_br = (g == 2); e_st = (m_lost == LIM);
    end
    chk("a_ready", 32'(a_ready), 32'(e_ar));
    chk("b_ready", 32'(b_ready), 32'(e_br));
    chk("starved", 32'(starved), 32'(e_st));
    @(posedge CLK);
    #1;
    if (v.rst) begin
      m_lost = 0; m_ew = 1'b0; m_rw = 5'd0; m_bus = 32'd0;
    end else begin
      if (g == 2 || !v.bv) m_lost = 0;
      else if (m_lost < LIM) m_lost++;
      if (g == 1) begin
        m_ew = (v.aa != 5'd0); m_rw = v.aa; m_bus = v.ad;
      end else if (g == 2) begin
        m_ew = (v.ba != 5'd0); m_rw = v.ba; m_bus = v.bd;
      end else begin
        m_ew = 1'b0;
      end
    end
    if (use_tbl) begin
      chk("ew", 32'(ew), 32'(v.ew));
      chk("rw", 32'(rw), 32'(v.rw));
      chk("busW", busW, v.bus);
    end else begin
      chk("ew", 32'(ew), 32'(m_ew));
      chk("rw", 32'(rw), 32'(m_rw));
      chk("busW", busW, m_bus);
    end
  endtask

  initial begin
    bit          ra_v, rb_v;
    logic [4:0]  ra_a, rb_a;
    logic [31:0] ra_d, rb_d;
    bit          rr;
    int          g;
    vec_t        v;

    RST = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = 5'd0; b_addr = 5'd0; a_data = 32'd0; b_data = 32'd0;
    @(posedge CLK);
    #1;
    m_lost = 0; m_ew = 1'b0; m_rw = 5'd0; m_bus = 32'd0;

    //          rst av aa     ad             bv ba     bd              ar br st  ew rw     bus
    tbl.push_back(mk(1, 1, 5'd3,  32'hAA,       1, 5'd4, 32'hBB,       0, 0, 0, 0, 5'd0,  32'h0));
    tbl.push_back(mk(0, 1, 5'd5,  32'h1234,     0, 5'd0, 32'h0,        1, 0, 0, 1, 5'd5,  32'h1234));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 0, 5'd5,  32'h1234));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0, 32'hFFFFFFFF, 0, 1, 0, 0, 5'd0,  32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, 5'd7,  32'h11,       1, 5'd7, 32'h22,       1, 0, 0, 1, 5'd7,  32'h11));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7, 32'h22,       0, 1, 0, 1, 5'd7,  32'h22));
    tbl.push_back(mk(0, 1, 5'd1,  32'h101,      1, 5'd9, 32'h909,      1, 0, 0, 1, 5'd1,  32'h101));
    tbl.push_back(mk(0, 1, 5'd2,  32'h102,      1, 5'd9, 32'h909,      1, 0, 0, 1, 5'd2,  32'h102));
    tbl.push_back(mk(0, 1, 5'd3,  32'h103,      1, 5'd9, 32'h909,      1, 0, 0, 1, 5'd3,  32'h103));
    tbl.push_back(mk(0, 1, 5'd4,  32'h104,      1, 5'd9, 32'h909,      0, 1, 1, 1, 5'd9,  32'h909));
    tbl.push_back(mk(0, 1, 5'd4,  32'h104,      1, 5'd9, 32'h919,      1, 0, 0, 1, 5'd4,  32'h104));
    tbl.push_back(mk(0, 1, 5'd5,  32'h105,      1, 5'd9, 32'h919,      1, 0, 0, 1, 5'd5,  32'h105));
    tbl.push_back(mk(0, 1, 5'd6,  32'h106,      1, 5'd9, 32'h919,      1, 0, 0, 1, 5'd6,  32'h106));
    tbl.push_back(mk(0, 1, 5'd7,  32'h107,      1, 5'd9, 32'h919,      0, 1, 1, 1, 5'd9,  32'h919));
    tbl.push_back(mk(0, 1, 5'd7,  32'h107,      1, 5'd9, 32'h929,      1, 0, 0, 1, 5'd7,  32'h107));
    tbl.push_back(mk(0, 1, 5'd8,  32'h108,      1, 5'd9, 32'h929,      1, 0, 0, 1, 5'd8,  32'h108));
    tbl.push_back(mk(1, 1, 5'd10, 32'h10A,      1, 5'd9, 32'h929,      0, 0, 0, 0, 5'd0,  32'h0));
    tbl.push_back(mk(0, 1, 5'd10, 32'h10A,      1, 5'd9, 32'h929,      1, 0, 0, 1, 5'd10, 32'h10A));
    tbl.push_back(mk(0, 1, 5'd11, 32'h10B,      1, 5'd9, 32'h929,      1, 0, 0, 1, 5'd11, 32'h10B));
    tbl.push_back(mk(0, 1, 5'd12, 32'h10C,      0, 5'd0, 32'h0,        1, 0, 0, 1, 5'd12, 32'h10C));
    tbl.push_back(mk(0, 1, 5'd13, 32'h10D,      1, 5'd9, 32'h939,      1, 0, 0, 1, 5'd13, 32'h10D));
    tbl.push_back(mk(0, 1, 5'd14, 32'h10E,      1, 5'd9, 32'h939,      1, 0, 0, 1, 5'd14, 32'h10E));
    tbl.push_back(mk(0, 1, 5'd15, 32'h10F,      1, 5'd9, 32'h939,      1, 0, 0, 1, 5'd15, 32'h10F));
    tbl.push_back(mk(0, 1, 5'd16, 32'h110,      1, 5'd9, 32'h939,      0, 1, 1, 1, 5'd9,  32'h939));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 0, 5'd9,  32'h939));

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // randomized traffic: each requester holds its request until accepted
    ra_v = 1'b0; rb_v = 1'b0;
    ra_a = 5'd0; rb_a = 5'd0; ra_d = 32'd0; rb_d = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      if (!ra_v && ($urandom_range(0, 3) != 0)) begin
        ra_v = 1'b1; ra_a = 5'($urandom_range(0, 31)); ra_d = $urandom;
      end
      if (!rb_v && ($urandom_range(0, 2) != 0)) begin
        rb_v = 1'b1; rb_a = 5'($urandom_range(0, 31)); rb_d = $urandom;
      end
      rr = ($urandom_range(0, 59) == 0);
      v = mk(rr, ra_v, ra_a, ra_d, rb_v, rb_a, rb_d, 0, 0, 0, 0, 5'd0, 32'd0);
      g = predict(rr, ra_v, rb_v);
      step(v, 1'b0);
      if (g == 1) ra_v = 1'b0;
      if (g == 2) rb_v = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
